// File: rtl/mem_tg_pkg.sv
// Shared types and constants for the memory traffic generator.
// No logic; state encoding, error counter width and request direction codes.
// Imported by mem_traffic_gen and mem_tg_shadow.
package mem_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } tg_state_t;

    localparam int ERR_W = 16;

    localparam logic REQ_WE_WRITE = 1'b1;
    localparam logic REQ_WE_READ  = 1'b0;

endpackage

// File: rtl/mem_tg_shadow.sv
// Shadow copy of everything the generator wrote, used to check read-back data.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the caller only writes on an accepted request.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module mem_tg_shadow
    import mem_tg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_traffic_gen.sv
// Write/read-back traffic generator: NUM_REQ LFSR writes, then NUM_REQ checked reads.
// Latency: first request one cycle after START; read data checked the cycle RSP_VALID is seen.
// Backpressure: REQ_VALID/REQ_READY handshake; reads throttled to MAX_OUTST in flight.
// Ports: CLK/RSTN; START; LFSR_IN pattern; REQ_* request port; RSP_* in-order read
// responses; BUSY/DONE run status; ERR_CNT/FIRST_ERR_ADDR check results.
module mem_traffic_gen
    import mem_tg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int NUM_REQ   = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [DATA_W-1:0] LFSR_IN,
    output logic              REQ_VALID,
    input  logic              REQ_READY,
    output logic              REQ_WE,
    output logic [ADDR_W-1:0] REQ_ADDR,
    output logic [DATA_W-1:0] REQ_WDATA,
    input  logic              RSP_VALID,
    input  logic [DATA_W-1:0] RSP_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR
);

    localparam logic [ADDR_W:0] LAST      = (ADDR_W+1)'(NUM_REQ - 1);
    localparam logic [3:0]      OUTST_MAX = 4'(MAX_OUTST);

    tg_state_t         state, state_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0]   wr_cnt, rd_cnt, rsp_cnt;
    logic [3:0]        outst;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err;
    logic [DATA_W-1:0] shadow_rdata;

    logic start_ok, wr_hs, rd_hs, rsp_hit, rsp_spur, rsp_bad, err_inc;

    assign start_ok = START && (state == ST_IDLE || state == ST_FIN);
    assign wr_hs    = (state == ST_WR) && REQ_READY;
    assign rd_hs    = (state == ST_RD) && REQ_VALID && REQ_READY;
    // A response with nothing outstanding cannot be matched to a read.
    assign rsp_hit  = RSP_VALID && (outst != 4'd0);
    assign rsp_spur = RSP_VALID && (outst == 4'd0);
    assign rsp_bad  = rsp_hit && (RSP_RDATA != shadow_rdata);
    assign err_inc  = rsp_spur || rsp_bad;

    assign ERR_CNT        = err_cnt;
    assign FIRST_ERR_ADDR = first_err;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        REQ_VALID = 1'b0;
        REQ_WE    = REQ_WE_READ;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) state_nxt = ST_WR;
            end
            ST_WR: begin
                REQ_VALID = 1'b1;
                REQ_WE    = REQ_WE_WRITE;
                REQ_ADDR  = wr_cnt[ADDR_W-1:0];
                REQ_WDATA = wdata_q;
                BUSY      = 1'b1;
                if (REQ_READY && wr_cnt == LAST) state_nxt = ST_RD;
            end
            ST_RD: begin
                REQ_VALID = (outst < OUTST_MAX);
                REQ_ADDR  = rd_cnt[ADDR_W-1:0];
                BUSY      = 1'b1;
                if (REQ_VALID && REQ_READY && rd_cnt == LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                BUSY = 1'b1;
                if (rsp_hit && rsp_cnt == LAST) state_nxt = ST_FIN;
            end
            ST_FIN: begin
                DONE = 1'b1;
                if (START) state_nxt = ST_WR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wdata_q   <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rsp_cnt   <= '0;
            outst     <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            // Reload the pattern on every accepted write so writes can stream.
            if (wr_hs) begin
                wr_cnt  <= wr_cnt + 1'b1;
                wdata_q <= LFSR_IN;
            end
            if (wr_hs && wr_cnt == LAST) begin
                rd_cnt  <= '0;
                rsp_cnt <= '0;
            end
            if (rd_hs)   rd_cnt  <= rd_cnt + 1'b1;
            if (rsp_hit) rsp_cnt <= rsp_cnt + 1'b1;
            // Read issue and response in the same cycle cancel out.
            case ({rd_hs, rsp_hit})
                2'b10:   outst <= outst + 4'd1;
                2'b01:   outst <= outst - 4'd1;
                default: outst <= outst;
            endcase
            if (err_inc) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) first_err <= rsp_hit ? rsp_cnt[ADDR_W-1:0] : '0;
            end
            // A new run wins over any error update in the same cycle.
            if (start_ok) begin
                wdata_q   <= LFSR_IN;
                wr_cnt    <= '0;
                err_cnt   <= '0;
                first_err <= '0;
            end
        end
    end

    mem_tg_shadow #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shadow (
        .clk     (CLK),
        .wr_en   (wr_hs),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (wdata_q),
        .rd_addr (rsp_cnt[ADDR_W-1:0]),
        .rd_data (shadow_rdata)
    );

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: external memory with configurable read latency,
// write stalls, read corruption, spurious responses and mid-run reset.
module tb_mem_traffic_gen;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int NR     = 8;
    localparam int MO     = 4;

    logic              CLK = 1'b0;
    logic              RSTN, START, REQ_READY, RSP_VALID;
    logic [DATA_W-1:0] LFSR_IN, RSP_RDATA;
    logic              REQ_VALID, REQ_WE, BUSY, DONE;
    logic [ADDR_W-1:0] REQ_ADDR, FIRST_ERR_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic [15:0]       ERR_CNT;

    mem_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NR), .MAX_OUTST(MO)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .LFSR_IN(LFSR_IN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // External memory and in-order read pipeline.
    logic [15:0] ext_mem [256];
    logic [15:0] rq_d [$];
    int          rq_t [$];
    int cyc = 0, lat = 2, corrupt_addr = -1, stall_addr = -1, stall_left = 0, stall_seen = 0;
    bit start_req = 0, inj_rsp = 0;

    // Reference model of the run, in terms of requests and responses.
    bit          run_active = 0;
    int          exp_wr = 0, exp_rd = 0, rsp_idx = 0, m_outst = 0, max_outst = 0;
    int          exp_err = 0, exp_first = 0, wr2_hits = 0;
    logic [15:0] next_wd = '0;
    logic [15:0] exp_shadow [256];

    function automatic bit busy_m();
        return run_active && (rsp_idx < NR);
    endfunction

    task automatic tick();
        bit e_vld, e_we;
        // Outputs as they stand after the previous edge.
        if (RSTN) begin
            e_we  = busy_m() && (exp_wr < NR);
            e_vld = e_we || (busy_m() && exp_wr == NR && exp_rd < NR && m_outst < MO);
            chk("req_vld", 32'(REQ_VALID), 32'(e_vld));
            chk("req_we", 32'(REQ_WE), 32'(e_we));
            chk("req_wdata", 32'(REQ_WDATA), e_we ? 32'(next_wd) : 32'd0);
            chk("busy", 32'(BUSY), 32'(busy_m()));
            chk("done", 32'(DONE), 32'(run_active && rsp_idx == NR));
            chk("err_cnt", 32'(ERR_CNT), 32'(exp_err));
            chk("first_err", 32'(FIRST_ERR_ADDR), 32'(exp_first));
        end
        // Drive this cycle's inputs.
        LFSR_IN   = 16'($urandom);
        START     = start_req;
        start_req = 0;
        RSP_VALID = 1'b0;
        RSP_RDATA = '0;
        if (inj_rsp) begin
            RSP_VALID = 1'b1;
            RSP_RDATA = 16'($urandom);
            inj_rsp   = 0;
        end else if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
            RSP_VALID = 1'b1;
            RSP_RDATA = rq_d.pop_front();
            void'(rq_t.pop_front());
        end
        REQ_READY = 1'b1;
        if (busy_m() && exp_wr == stall_addr && stall_left > 0) begin
            REQ_READY = 1'b0;
            stall_left--;
            stall_seen++;
            chk("stall_addr", 32'(REQ_ADDR), 32'(stall_addr));
            chk("stall_we", 32'(REQ_WE), 32'd1);
            chk("stall_wdata", 32'(REQ_WDATA), 32'(next_wd));
        end
        // Model the effect of the coming edge.
        if (RSTN) begin
            if (RSP_VALID) begin
                if (m_outst == 0) begin
                    if (exp_err == 0) exp_first = 0;
                    exp_err++;
                end else begin
                    if (RSP_RDATA != exp_shadow[rsp_idx]) begin
                        if (exp_err == 0) exp_first = rsp_idx;
                        exp_err++;
                    end
                    rsp_idx++;
                    m_outst--;
                end
            end
            if (REQ_VALID && REQ_READY) begin
                if (REQ_WE) begin
                    chk("wr_addr", 32'(REQ_ADDR), 32'(exp_wr));
                    chk("wr_data", 32'(REQ_WDATA), 32'(next_wd));
                    ext_mem[REQ_ADDR]  = REQ_WDATA;
                    exp_shadow[exp_wr] = next_wd;
                    next_wd = LFSR_IN;
                    if (REQ_ADDR == 8'd2) wr2_hits++;
                    exp_wr++;
                end else begin
                    chk("rd_addr", 32'(REQ_ADDR), 32'(exp_rd));
                    rq_d.push_back(ext_mem[REQ_ADDR] ^
                                   ((int'(REQ_ADDR) == corrupt_addr) ? 16'h0001 : 16'h0000));
                    rq_t.push_back(cyc + lat);
                    exp_rd++;
                    m_outst++;
                    if (m_outst > max_outst) max_outst = m_outst;
                end
            end
            if (START && !busy_m()) begin
                run_active = 1;
                exp_wr = 0; exp_rd = 0; rsp_idx = 0;
                exp_err = 0; exp_first = 0; wr2_hits = 0;
                next_wd = LFSR_IN;
            end
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic start_run();
        start_req = 1;
        tick();
        chk("first_req_vld", 32'(REQ_VALID), 32'd1);
        chk("first_req_addr", 32'(REQ_ADDR), 32'd0);
        chk("start_busy", 32'(BUSY), 32'd1);
        chk("start_done_clr", 32'(DONE), 32'd0);
        chk("start_err_clr", 32'(ERR_CNT), 32'd0);
    endtask

    task automatic finish_run();
        for (int i = 0; i < 600 && busy_m(); i++) tick();
        chk("run_in_time", 32'(busy_m()), 32'd0);
        chk("end_done", 32'(DONE), 32'd1);
        chk("end_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RSTN = 1'b1; START = 1'b0; REQ_READY = 1'b1; RSP_VALID = 1'b0;
        LFSR_IN = '0; RSP_RDATA = '0;
        #2 RSTN = 1'b0;
        #1;
        chk("rst_vld", 32'(REQ_VALID), 32'd0);
        chk("rst_we", 32'(REQ_WE), 32'd0);
        chk("rst_addr", 32'(REQ_ADDR), 32'd0);
        chk("rst_wdata", 32'(REQ_WDATA), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR_CNT), 32'd0);
        chk("rst_first", 32'(FIRST_ERR_ADDR), 32'd0);
        @(negedge CLK);
        tick();
        tick();
        RSTN = 1'b1;
        tick();

        // Stray response while idle.
        inj_rsp = 1;
        tick();
        tick();
        chk("idle_spur_err", 32'(ERR_CNT), 32'd1);
        chk("idle_spur_first", 32'(FIRST_ERR_ADDR), 32'd0);

        // Clean run, 2-cycle read latency.
        lat = 2;
        start_run();
        finish_run();
        chk("clean_err", 32'(ERR_CNT), 32'd0);

        // Write to address 2 held off for 3 cycles; restart from FIN.
        stall_addr = 2; stall_left = 3; stall_seen = 0;
        start_run();
        finish_run();
        chk("stall_cycles", 32'(stall_seen), 32'd3);
        chk("stall_one_write", 32'(wr2_hits), 32'd1);
        chk("stall_err", 32'(ERR_CNT), 32'd0);
        stall_addr = -1;

        // Corrupted read-back of address 2.
        corrupt_addr = 2;
        start_run();
        finish_run();
        chk("corrupt_err", 32'(ERR_CNT), 32'd1);
        chk("corrupt_first", 32'(FIRST_ERR_ADDR), 32'd2);
        corrupt_addr = -1;

        // Long latency: read throttling, plus START ignored mid-write.
        lat = 10; max_outst = 0;
        start_run();
        tick();
        tick();
        start_req = 1;
        tick();
        chk("start_ignored_addr", 32'(REQ_ADDR), 32'(exp_wr));
        chk("start_ignored_busy", 32'(BUSY), 32'd1);
        finish_run();
        chk("max_outst", 32'(max_outst), 32'(MO));
        chk("lat10_err", 32'(ERR_CNT), 32'd0);

        // Reset with two reads outstanding; late responses become spurious.
        start_run();
        for (int i = 0; i < 200 && m_outst != 2; i++) tick();
        chk("two_outstanding", 32'(m_outst), 32'd2);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(REQ_VALID), 32'd0);
        chk("mid_rst_we", 32'(REQ_WE), 32'd0);
        chk("mid_rst_addr", 32'(REQ_ADDR), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_done", 32'(DONE), 32'd0);
        run_active = 0; m_outst = 0; exp_err = 0; exp_first = 0;
        @(negedge CLK);
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 100 && rq_t.size() > 0; i++) tick();
        chk("late_rsp_err", 32'(ERR_CNT), 32'd2);
        chk("late_rsp_first", 32'(FIRST_ERR_ADDR), 32'd0);
        start_run();
        finish_run();
        chk("after_rst_err", 32'(ERR_CNT), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
